// File: rtl/mfcc_delta_pkg.sv
// Shared definitions for the MFCC delta blocks: window length, the Q1.15
// reciprocal of the delta-delta normaliser, FSM encodings and slot arithmetic.
package mfcc_delta_pkg;

  localparam int WIN_LEN    = 5;
  localparam int RECIP_1_10 = 3277;  // round(2^15/10)

  localparam logic [1:0] ST_FILL  = 2'd0;
  localparam logic [1:0] ST_CALC  = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  // (s - d) mod WIN_LEN for s < WIN_LEN, d <= WIN_LEN
  function automatic logic [2:0] slot_sub(input logic [2:0] s, input logic [2:0] d);
    logic [3:0] t;
    t = {1'b0, s} + 4'(WIN_LEN) - {1'b0, d};
    if (t >= 4'(WIN_LEN)) t = t - 4'(WIN_LEN);
    return t[2:0];
  endfunction

endpackage

// File: rtl/delta2_mac.sv
// Delta-delta datapath: num = 2*(t+2 - t-2) + (t+1 - t-1), scaled by the
// Q1.15 reciprocal, rounded half-up and registered.
// DELTA2_SATURATE_EN: clamp to the DATA_WIDTH range and report the clamp;
// otherwise the result wraps to the low DATA_WIDTH bits.
module delta2_mac #(
  parameter int DATA_WIDTH = 16,
  parameter int RECIP      = mfcc_delta_pkg::RECIP_1_10
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         i_en,
  input  logic signed [DATA_WIDTH-1:0] i_tp2,
  input  logic signed [DATA_WIDTH-1:0] i_tp1,
  input  logic signed [DATA_WIDTH-1:0] i_tm1,
  input  logic signed [DATA_WIDTH-1:0] i_tm2,
`ifdef DELTA2_SATURATE_EN
  output logic                         o_clamp,
`endif
  output logic signed [DATA_WIDTH-1:0] o_data
);

  localparam int NW = DATA_WIDTH + 3;
  localparam int PW = DATA_WIDTH + 19;
  localparam int RW = PW - 15;

  localparam logic signed [PW-1:0] C_RECIP = PW'(RECIP);
  localparam logic signed [PW-1:0] C_HALF  = PW'(16384);
  localparam logic signed [RW-1:0] C_MAX   = RW'((64'sd1 <<< (DATA_WIDTH-1)) - 64'sd1);
  localparam logic signed [RW-1:0] C_MIN   = ~C_MAX;

  logic signed [NW-1:0]         w_a, w_b, w_c, w_d, w_num;
  logic signed [PW-1:0]         w_numx, w_prod, w_rnd;
  logic signed [RW-1:0]         w_full;
  logic signed [DATA_WIDTH-1:0] w_out;
  logic                         w_unused;

  assign w_a    = {{3{i_tp2[DATA_WIDTH-1]}}, i_tp2};
  assign w_b    = {{3{i_tp1[DATA_WIDTH-1]}}, i_tp1};
  assign w_c    = {{3{i_tm1[DATA_WIDTH-1]}}, i_tm1};
  assign w_d    = {{3{i_tm2[DATA_WIDTH-1]}}, i_tm2};
  assign w_num  = ((w_a - w_d) <<< 1) + (w_b - w_c);
  assign w_numx = {{(PW-NW){w_num[NW-1]}}, w_num};
  assign w_prod = w_numx * C_RECIP;
  assign w_rnd  = w_prod + C_HALF;
  // arithmetic >>> 15 by slicing: floor division keeps round-half-up for negatives
  assign w_full = w_rnd[PW-1:15];

`ifdef DELTA2_SATURATE_EN
  logic w_hi, w_lo;
  assign w_hi     = (w_full > C_MAX);
  assign w_lo     = (w_full < C_MIN);
  assign o_clamp  = w_hi | w_lo;
  assign w_out    = w_hi ? C_MAX[DATA_WIDTH-1:0] :
                    w_lo ? C_MIN[DATA_WIDTH-1:0] : w_full[DATA_WIDTH-1:0];
  assign w_unused = ^w_rnd[14:0];
`else
  assign w_out    = w_full[DATA_WIDTH-1:0];
  assign w_unused = ^{w_rnd[14:0], w_full[RW-1:DATA_WIDTH]};
`endif

  // output register; holds while not enabled so stalls keep data stable
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    o_data <= '0;
    else if (i_en) o_data <= w_out;
  end

endmodule

// File: rtl/delta_2nd_window_calc.sv
// Second-order delta over a 5-frame window. Frames are written one coef per
// cycle into a circular 5-slot buffer; once 5 frames are held, each new frame
// triggers one output frame for the centre frame t.
// DELTA2_SATURATE_EN: adds sticky o_sat_flag and clamps outputs.
module delta_2nd_window_calc #(
  parameter int DATA_WIDTH = 16,
  parameter int NUM_COEF   = 13,
  parameter int COEF_W     = 4,
  parameter int RECIP_1_10 = mfcc_delta_pkg::RECIP_1_10
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         i_flush,
  input  logic                         i_in_valid,
  output logic                         o_in_ready,
  input  logic signed [DATA_WIDTH-1:0] i_in_data,
  output logic                         o_out_valid,
  input  logic                         i_out_ready,
  output logic signed [DATA_WIDTH-1:0] o_out_data,
  output logic [COEF_W-1:0]            o_out_idx,
  output logic                         o_out_last,
`ifdef DELTA2_SATURATE_EN
  output logic                         o_sat_flag,
`endif
  output logic                         o_frame_done
);
  import mfcc_delta_pkg::*;

  logic [WIN_LEN-1:0][NUM_COEF-1:0][DATA_WIDTH-1:0] r_buf;
  logic [1:0]        r_state;
  logic [2:0]        r_wr_slot, r_fill_cnt;
  logic [COEF_W-1:0] r_wr_idx, r_rd_idx, r_out_idx;
  logic              r_issue_done, r_out_valid, r_out_last, r_frame_done;
  logic              w_in_xfer, w_wr_last, w_adv, w_issue, w_last_acc;
  logic [2:0]        w_n, w_n1, w_n3;

  assign o_in_ready   = (r_state == ST_FILL);
  assign o_out_valid  = r_out_valid;
  assign o_out_idx    = r_out_idx;
  assign o_out_last   = r_out_last;
  assign o_frame_done = r_frame_done;

  assign w_in_xfer  = i_in_valid & o_in_ready & ~i_flush;
  assign w_wr_last  = (r_wr_idx == COEF_W'(NUM_COEF-1));
  assign w_adv      = ~r_out_valid | i_out_ready;
  assign w_issue    = (r_state == ST_CALC) & ~r_issue_done & w_adv & ~i_flush;
  assign w_last_acc = (r_state == ST_CALC) & r_out_valid & i_out_ready & r_out_last;

  // newest slot is the one just behind the write pointer; t-2 is the write pointer itself
  assign w_n  = slot_sub(r_wr_slot, 3'd1);
  assign w_n1 = slot_sub(r_wr_slot, 3'd2);
  assign w_n3 = slot_sub(r_wr_slot, 3'd4);

  // coefficient storage, written on each accepted input
  always_ff @(posedge clk) begin
    if (w_in_xfer) r_buf[r_wr_slot][r_wr_idx] <= i_in_data;
  end

  // window pointers, FSM and output handshake; flush wins over everything but reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_FILL;
      r_wr_slot    <= '0;
      r_wr_idx     <= '0;
      r_fill_cnt   <= '0;
      r_rd_idx     <= '0;
      r_issue_done <= 1'b0;
      r_out_valid  <= 1'b0;
      r_out_idx    <= '0;
      r_out_last   <= 1'b0;
      r_frame_done <= 1'b0;
    end else if (i_flush) begin
      r_state      <= ST_FILL;
      r_wr_slot    <= '0;
      r_wr_idx     <= '0;
      r_fill_cnt   <= '0;
      r_rd_idx     <= '0;
      r_issue_done <= 1'b0;
      r_out_valid  <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_frame_done <= 1'b0;
      case (r_state)
        ST_FILL: begin
          if (w_in_xfer) begin
            if (w_wr_last) begin
              r_wr_idx   <= '0;
              r_wr_slot  <= (r_wr_slot == 3'(WIN_LEN-1)) ? 3'd0 : r_wr_slot + 3'd1;
              r_fill_cnt <= (r_fill_cnt == 3'(WIN_LEN)) ? r_fill_cnt : r_fill_cnt + 3'd1;
              if (r_fill_cnt >= 3'(WIN_LEN-1)) r_state <= ST_CALC;
            end else begin
              r_wr_idx <= r_wr_idx + COEF_W'(1);
            end
          end
        end
        ST_CALC: begin
          if (w_issue) begin
            r_out_valid <= 1'b1;
            r_out_idx   <= r_rd_idx;
            r_out_last  <= (r_rd_idx == COEF_W'(NUM_COEF-1));
            if (r_rd_idx == COEF_W'(NUM_COEF-1)) r_issue_done <= 1'b1;
            else                                 r_rd_idx     <= r_rd_idx + COEF_W'(1);
          end else if (w_adv) begin
            r_out_valid <= 1'b0;
          end
          if (w_last_acc) begin
            r_state      <= ST_DRAIN;
            r_frame_done <= 1'b1;
          end
        end
        ST_DRAIN: begin
          r_state      <= ST_FILL;
          r_rd_idx     <= '0;
          r_issue_done <= 1'b0;
        end
        default: r_state <= ST_FILL;
      endcase
    end
  end

`ifdef DELTA2_SATURATE_EN
  logic w_clamp;
  // sticky clamp indicator, only counted for values actually loaded
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                  o_sat_flag <= 1'b0;
    else if (i_flush)            o_sat_flag <= 1'b0;
    else if (w_issue & w_clamp)  o_sat_flag <= 1'b1;
  end
`endif

  delta2_mac #(
    .DATA_WIDTH (DATA_WIDTH),
    .RECIP      (RECIP_1_10)
  ) u_mac (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_en    (w_issue),
    .i_tp2   (r_buf[w_n][r_rd_idx]),
    .i_tp1   (r_buf[w_n1][r_rd_idx]),
    .i_tm1   (r_buf[w_n3][r_rd_idx]),
    .i_tm2   (r_buf[r_wr_slot][r_rd_idx]),
`ifdef DELTA2_SATURATE_EN
    .o_clamp (w_clamp),
`endif
    .o_data  (o_out_data)
  );

endmodule
